// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared VGA timing constants and scan-out FSM states
package vga_fb_pkg;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] H_TOTAL = 10'd800;
    localparam logic [9:0] V_TOTAL = 10'd525;
    localparam logic [31:0] WORDS_PER_LINE = 32'd40;
    localparam int LATENCY = 3;
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, SCAN} state_t;
endpackage

// File: rtl/rgb332_expand.sv
// rgb332_expand: widens an RGB332 pixel to 8 bits per channel by bit replication
module rgb332_expand (
    input  logic [7:0] px,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);
    assign r = {px[7:5], px[7:5], px[7:6]};
    assign g = {px[4:2], px[4:2], px[4:3]};
    assign b = {4{px[1:0]}};
endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: scans a double-buffered 160x120 RGB332 framebuffer out to a VGA DAC
module vga_fb_reader
    import vga_fb_pkg::*;
#(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] BASE1 = 32'h0000_1400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        sync_b_i,
    input  logic        blank_b_i,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_q,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        sync_b_o,
    output logic        blank_b_o,
    output logic [15:0] frame_cnt
);
    state_t state, state_nx;
    logic act, swap_pt, do_swap, vis1, vis2, base_sel, swap_pending;
    logic [1:0] lane1, lane2;
    logic [3:0] sp [LATENCY];
    logic [7:0] px, er, eg, eb;
    assign act = (x < H_ACTIVE) && (y < V_ACTIVE);
    assign swap_pt = (x == 10'd0) && (y == V_ACTIVE);
    assign do_swap = swap_pt && (swap_pending || swap_req);
    assign px = mem_q[{lane2, 3'b000} +: 8];
    assign {hsync_o, vsync_o, sync_b_o, blank_b_o} = sp[LATENCY-1];
    rgb332_expand u_exp (.px(px), .r(er), .g(eg), .b(eb));
    always_comb begin
        state_nx = state;
        state_nx = !en ? IDLE :
                   (state == IDLE) ? WAIT_FRAME :
                   (state == WAIT_FRAME && x == H_TOTAL - 10'd1 && y == V_TOTAL - 10'd1) ? SCAN : state;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            base_sel <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack <= 1'b0;
            frame_cnt <= 16'd0;
            mem_addr <= BASE0;
            vis1 <= 1'b0;
            vis2 <= 1'b0;
            lane1 <= 2'd0;
            lane2 <= 2'd0;
            r <= 8'd0;
            g <= 8'd0;
            b <= 8'd0;
            for (int i = 0; i < LATENCY; i++) sp[i] <= 4'b1100;
        end else begin
            state <= state_nx;
            if (act) mem_addr <= (base_sel ? BASE1 : BASE0) + 32'(y[9:2]) * WORDS_PER_LINE + 32'(x[9:4]);
            // visibility is judged at fetch time and travels alongside the RAM access
            vis1 <= act && blank_b_i && (state == SCAN);
            lane1 <= x[3:2];
            vis2 <= vis1;
            lane2 <= lane1;
            r <= vis2 ? er : 8'd0;
            g <= vis2 ? eg : 8'd0;
            b <= vis2 ? eb : 8'd0;
            sp[0] <= {hsync_i, vsync_i, sync_b_i, blank_b_i};
            for (int i = 1; i < LATENCY; i++) sp[i] <= sp[i-1];
            swap_ack <= do_swap;
            base_sel <= do_swap ? ~base_sel : base_sel;
            swap_pending <= do_swap ? 1'b0 : (swap_pending || swap_req);
            if (swap_pt && state == SCAN) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed self-checking bench with a one-cycle-latency RAM model
module tb_vga_fb_reader;
    logic clk = 1'b0;
    logic rst, en, hsync_i, vsync_i, sync_b_i, blank_b_i, swap_req, swap_ack;
    logic hsync_o, vsync_o, sync_b_o, blank_b_o;
    logic [9:0] x, y;
    logic [31:0] mem_addr, mem_q;
    logic [7:0] r, g, b;
    logic [15:0] frame_cnt;
    logic [31:0] ram [0:16383];
    int total = 0;
    int bad = 0;

    vga_fb_reader dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .y(y),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .sync_b_i(sync_b_i), .blank_b_i(blank_b_i),
        .mem_addr(mem_addr), .mem_q(mem_q), .swap_req(swap_req), .swap_ack(swap_ack),
        .r(r), .g(g), .b(b),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .sync_b_o(sync_b_o), .blank_b_o(blank_b_o),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_q <= ram[mem_addr[13:0]];

    task automatic tick(input logic [9:0] xx, input logic [9:0] yy);
        x = xx;
        y = yy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, r, g, b};
    endfunction

    function automatic logic [31:0] strobes();
        return {28'd0, hsync_o, vsync_o, sync_b_o, blank_b_o};
    endfunction

    function automatic logic [31:0] lane_rgb(input int l);
        return l == 0 ? 32'hFFFFFF : l == 1 ? 32'h00FF00 : l == 2 ? 32'hFF0000 : 32'h0000FF;
    endfunction

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'd0;
        ram[0] = 32'h03E01CFF;
        ram[360] = 32'hFFFFFFFF;
        ram[366] = 32'h00001C00;
        ram[5120] = 32'hE0E0E0E0;
        rst = 1'b0; en = 1'b1; swap_req = 1'b0;
        {hsync_i, vsync_i, sync_b_i, blank_b_i} = 4'b1111;
        tick(0, 0);
        tick(320, 240);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rgb", rgb(), 32'd0);
        chk("rst_ack", {31'd0, swap_ack}, 32'd0);
        chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_strobes", strobes(), 32'hC);
        rst = 1'b1;
        tick(0, 0); tick(1, 0); tick(2, 0);
        chk("wait_frame_black", rgb(), 32'd0);
        tick(799, 524);
        for (int i = 0; i < 18; i++) begin
            tick(10'(i), 0);
            if (i < 2) chk("latency_early", rgb(), 32'd0);
            else chk($sformatf("pix_x%0d", i - 2), rgb(), lane_rgb((i - 2) / 4));
        end
        tick(100, 37);
        chk("addr_100_37", mem_addr, 32'd366);
        tick(700, 37);
        chk("addr_hold", mem_addr, 32'd366);
        {hsync_i, vsync_i, sync_b_i, blank_b_i} = 4'b0100;
        tick(5, 37);
        chk("lane1_green", rgb(), 32'h00FF00);
        {hsync_i, vsync_i, sync_b_i, blank_b_i} = 4'b1111;
        tick(6, 37);
        chk("x700_black", rgb(), 32'd0);
        chk("strobe_not_early", strobes(), 32'hF);
        tick(7, 37);
        chk("blank_black", rgb(), 32'd0);
        chk("strobe_delay3", strobes(), 32'h4);
        tick(8, 37);
        chk("unblank_white", rgb(), 32'hFFFFFF);
        chk("strobe_restore", strobes(), 32'hF);
        swap_req = 1'b1; tick(0, 200);
        swap_req = 1'b0; tick(5, 200);
        swap_req = 1'b1; tick(0, 300);
        swap_req = 1'b0;
        tick(0, 480);
        chk("swap_ack_pulse", {31'd0, swap_ack}, 32'd1);
        chk("fcnt_1", {16'd0, frame_cnt}, 32'd1);
        tick(1, 480);
        chk("swap_ack_end", {31'd0, swap_ack}, 32'd0);
        tick(799, 524);
        tick(0, 0);
        chk("addr_base1", mem_addr, 32'd5120);
        tick(1, 0); tick(2, 0);
        chk("base1_red", rgb(), 32'hFF0000);
        tick(0, 480);
        chk("no_extra_swap_ack", {31'd0, swap_ack}, 32'd0);
        chk("fcnt_2", {16'd0, frame_cnt}, 32'd2);
        tick(0, 0);
        chk("still_base1", mem_addr, 32'd5120);
        tick(1, 0); tick(2, 0);
        chk("pre_reset_red", rgb(), 32'hFF0000);
        rst = 1'b0;
        tick(320, 240);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_rgb", rgb(), 32'd0);
        chk("mid_rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        chk("mid_rst_strobes", strobes(), 32'hC);
        tick(320, 240);
        rst = 1'b1;
        tick(0, 0); tick(1, 0); tick(2, 0);
        chk("post_rst_black", rgb(), 32'd0);
        tick(799, 524); tick(0, 0); tick(1, 0); tick(2, 0);
        chk("post_rst_white", rgb(), 32'hFFFFFF);
        chk("post_rst_base0", mem_addr, 32'd0);
        tick(0, 1); tick(1, 1);
        en = 1'b0;
        tick(2, 1); tick(3, 1); tick(4, 1);
        chk("en_drop_last_pix", rgb(), 32'hFFFFFF);
        tick(5, 1);
        chk("en_drop_black", rgb(), 32'd0);
        en = 1'b1;
        tick(0, 2); tick(1, 2); tick(2, 2); tick(3, 2);
        chk("reen_wait_black", rgb(), 32'd0);
        tick(799, 524); tick(0, 0); tick(1, 0); tick(2, 0);
        chk("reen_white", rgb(), 32'hFFFFFF);
        repeat (65535) tick(0, 480);
        chk("fcnt_ffff", {16'd0, frame_cnt}, 32'h0000FFFF);
        tick(0, 480);
        chk("fcnt_wrap", {16'd0, frame_cnt}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
